// File: rtl/mux_rr_scan.sv
// Registered CH:1 channel mux with direct-select and round-robin scan modes.
// Optional grant counter output is enabled by defining MUX_GRANT_CNT_EN.
module mux_rr_scan #(
    parameter int CH = 16,
    parameter int W  = 1,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] in,
    input  logic [CH-1:0]   in_vld,
    output logic [CH-1:0]   in_ack,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out,
    output logic [SW-1:0]   out_ch,
    output logic            out_vld,
    input  logic            out_rdy
`ifdef MUX_GRANT_CNT_EN
    ,
    output logic [15:0]     grant_cnt
`endif
);

    typedef struct packed {
        logic          vld;
        logic [SW-1:0] ch;
        logic [W-1:0]  data;
    } oreg_t;

    logic [CH-1:0][W-1:0] ch_data;
    oreg_t                oreg;
    logic [SW-1:0]        ptr;
    logic [SW-1:0]        idx;
    logic [SW-1:0]        scan_gnt;
    logic                 scan_hit;
    logic [SW-1:0]        gnt;
    logic                 hit;
    logic                 load;
    logic                 take;

    assign ch_data = in;
    assign load    = !oreg.vld || out_rdy;

    // Walk offsets from farthest to nearest so the lowest offset from ptr wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_gnt = ptr;
        idx      = ptr;
        for (int i = CH-1; i >= 0; i--) begin
            idx = ptr + SW'(i);
            if (in_vld[idx]) begin
                scan_hit = 1'b1;
                scan_gnt = idx;
            end
        end
    end

    assign gnt  = mode ? scan_gnt : sel;
    assign hit  = mode ? scan_hit : in_vld[sel];
    assign take = load && hit;

    // Ack is the capture strobe for the current edge; forced low while in reset.
    always_comb begin
        in_ack = '0;
        if (take && rst_n)
            in_ack = CH'(1) << gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg <= '0;
            ptr  <= '0;
        end else if (load) begin
            if (hit) begin
                oreg.vld  <= 1'b1;
                oreg.ch   <= gnt;
                oreg.data <= ch_data[gnt];
                if (mode)
                    ptr <= gnt + SW'(1);
            end else begin
                oreg.vld <= 1'b0;
            end
        end
    end

    assign out     = oreg.data;
    assign out_ch  = oreg.ch;
    assign out_vld = oreg.vld;

`ifdef MUX_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            grant_cnt <= '0;
        else if (take && grant_cnt != 16'hFFFF)
            grant_cnt <= grant_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mux_rr_scan.sv
// Randomized bench for mux_rr_scan against a cycle-level behavioural model.
module tb_mux_rr_scan;
    localparam int CH = 16;
    localparam int W  = 8;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH*W-1:0] in_bus = '0;
    logic [CH-1:0]   in_vld = '0;
    logic [CH-1:0]   in_ack;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [W-1:0]    out;
    logic [SW-1:0]   out_ch;
    logic            out_vld;
    logic            out_rdy = 1'b0;
`ifdef MUX_GRANT_CNT_EN
    logic [15:0]     grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr = 0;
    int          m_ch  = 0;
    logic [W-1:0] m_out = '0;
    bit          m_vld = 1'b0;
    int          m_cnt = 0;
    logic [CH-1:0] exp_ack;
    logic [W-1:0]  held;

    always #5 clk = ~clk;

    mux_rr_scan #(.CH(CH), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_bus),
        .in_vld  (in_vld),
        .in_ack  (in_ack),
        .mode    (mode),
        .sel     (sel),
        .out     (out),
        .out_ch  (out_ch),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
`ifdef MUX_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the spec's rules: predict this cycle's ack and next output state.
    task automatic model_step();
        bit found = 1'b0;
        int g = 0;
        exp_ack = '0;
        if (!m_vld || out_rdy) begin
            if (!mode) begin
                if (in_vld[sel]) begin found = 1'b1; g = int'(sel); end
            end else begin
                for (int k = 0; k < CH; k++)
                    if (!found && in_vld[(m_ptr + k) % CH]) begin
                        found = 1'b1;
                        g = (m_ptr + k) % CH;
                    end
            end
            if (found) begin
                exp_ack[g] = 1'b1;
                m_out = in_bus[g*W +: W];
                m_ch  = g;
                m_vld = 1'b1;
                if (mode) m_ptr = (g + 1) % CH;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic cycle();
        #3;
        model_step();
        chk("in_ack", 32'(in_ack), 32'(exp_ack));
        @(posedge clk);
        #1;
        chk("out_vld", 32'(out_vld), 32'(m_vld));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
        chk("out", 32'(out), 32'(m_out));
`ifdef MUX_GRANT_CNT_EN
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic rand_data();
        for (int k = 0; k < CH; k++) in_bus[k*W +: W] = W'($urandom);
    endtask

    initial begin
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_vld", 32'(out_vld), 0);
        chk("rst_ack", 32'(in_ack), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // direct select of channel 5
        rand_data();
        in_bus[5*W +: W] = 8'hA5;
        mode = 1'b0; sel = 4'd5; in_vld = 16'h0020; out_rdy = 1'b1;
        #2;
        chk("dir_ack", 32'(in_ack), 32'h0020);
        cycle();
        chk("dir_out", 32'(out), 32'hA5);
        chk("dir_ch", 32'(out_ch), 5);

        // empty after a transfer
        in_vld = '0;
        rand_data();
        cycle();
        chk("empty_vld", 32'(out_vld), 0);
        chk("empty_out", 32'(out), 32'hA5);

        // scan wrap between channels 0 and 15
        mode = 1'b1; in_vld = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
            chk("scan_wrap", 32'(out_ch), (i % 2) ? 15 : 0);
        end

        // stall holding channel 3
        mode = 1'b0; sel = 4'd3; in_vld = 16'h0008; rand_data();
        cycle();
        held = out;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            sel = SW'($urandom);
            mode = 1'($urandom);
            in_vld = CH'($urandom) | 16'h0008;
            #2;
            chk("stall_ack", 32'(in_ack), 0);
            cycle();
            chk("stall_out", 32'(out), 32'(held));
            chk("stall_ch", 32'(out_ch), 3);
        end
        out_rdy = 1'b1; mode = 1'b0; sel = 4'd3; in_vld = 16'h0008;
        rand_data();
        held = in_bus[3*W +: W];
        cycle();
        chk("resume_out", 32'(out), 32'(held));
        chk("resume_vld", 32'(out_vld), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            mode = 1'($urandom);
            sel = SW'($urandom);
            case ($urandom_range(0, 3))
                0: in_vld = '0;
                1: in_vld = CH'($urandom);
                default: in_vld = CH'($urandom & $urandom & $urandom);
            endcase
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // asynchronous reset mid-transfer, then scan restarts at channel 0
        mode = 1'b1; in_vld = 16'hFFF0; out_rdy = 1'b1; rand_data();
        cycle();
        chk("pre_rst_vld", 32'(out_vld), 1);
        in_vld = '1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_vld), 0);
        chk("arst_out", 32'(out), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_ack", 32'(in_ack), 0);
        m_vld = 1'b0; m_out = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_data();
        cycle();
        chk("post_rst_ch", 32'(out_ch), 0);
        cycle();
        chk("post_rst_ch2", 32'(out_ch), 1);

`ifdef MUX_GRANT_CNT_EN
        mode = 1'b1; in_vld = '1; out_rdy = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(grant_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_hold", 32'(grant_cnt), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_scan.md
MUX_RR_SCAN -- requirements
Module: mux_rr_scan

Interface
REQ-001 SHALL have parameter CH, default 16, number of input channels; power of two, 2..64.
REQ-002 SHALL have parameter W, default 1, data width per channel.
REQ-003 SHALL have derived parameter SW = log2(CH), the select and tag width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port in, input, CH*W, flat channel data; channel k occupies bits [k*W +: W].
REQ-007 SHALL have port in_vld, input, CH, per-channel valid; bit k qualifies channel k.
REQ-008 SHALL have port in_ack, output, CH, one-hot single-cycle pulse marking the channel captured this cycle; all zero otherwise.
REQ-009 SHALL have port mode, input, 1, selection mode: 0 = direct select, 1 = round-robin scan.
REQ-010 SHALL have port sel, input, SW, channel index used in direct mode.
REQ-011 SHALL have port out, output, W, registered selected data.
REQ-012 SHALL have port out_ch, output, SW, registered index of the channel held in out.
REQ-013 SHALL have port out_vld, output, 1, out and out_ch hold valid data.
REQ-014 SHALL have port out_rdy, input, 1, downstream accept.

Function
REQ-015 Load condition: load = !out_vld || out_rdy, evaluated each cycle.
REQ-016 Direct mode: when load and in_vld[sel] = 1, SHALL register in[sel] into out, sel into out_ch, set out_vld, and pulse in_ack[sel].
REQ-017 Scan mode: when load, SHALL search channels ptr, ptr+1, ... mod CH and grant the first with in_vld set.
REQ-018 Scan mode grant: SHALL register the granted channel's data and index, set out_vld, pulse its in_ack bit, and set ptr = (grant+1) mod CH.
REQ-019 Scan wrap-around: grant at CH-1 SHALL set ptr to 0; search from ptr SHALL wrap past CH-1 to 0.
REQ-020 No candidate when load is true (direct: in_vld[sel] = 0; scan: in_vld all zero): SHALL clear out_vld, hold out and out_ch, keep in_ack zero, leave ptr unchanged.
REQ-021 Stall (out_vld = 1, out_rdy = 0): out, out_ch, out_vld SHALL hold stable; in_ack SHALL stay zero; ptr SHALL hold.
REQ-022 Simultaneous accept and new valid input: SHALL capture the new data in the same cycle, giving full throughput of one transfer per clock.
REQ-023 Latency: capture is one clock from sampled in_vld to out_vld.
REQ-024 ptr SHALL persist across mode changes; a mode change takes effect on the next load cycle only.
REQ-025 sel and mode changes while stalled SHALL NOT alter held output.
REQ-026 At most one in_ack bit SHALL be set per cycle.

Reset
REQ-027 rst_n low SHALL immediately force out = 0, out_ch = 0, out_vld = 0, in_ack = 0, ptr = 0, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; the first load after release SHALL see an empty output register.

Configuration
REQ-029 Macro MUX_GRANT_CNT_EN defined: SHALL add output grant_cnt, 16 bits, incrementing on every in_ack pulse, saturating at 0xFFFF, reset to 0.
REQ-030 Macro MUX_GRANT_CNT_EN undefined: grant_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Direct mode, CH=16, W=8: sel=5, in_vld[5]=1, in[5]=0xA5, out_rdy=1 -> next cycle out=0xA5, out_ch=5, out_vld=1; in_ack=0x0020 for one cycle.
REQ-032 Scan mode with in_vld=0x8001 constantly, out_rdy=1 -> out_ch sequence 0,15,0,15; ptr wraps correctly.
REQ-033 Stall: out_vld=1, out_ch=3, out_rdy=0 for 4 cycles while in[3] and sel change -> out, out_ch held, in_ack=0; after out_rdy=1, next grant occurs.
REQ-034 Empty: in_vld=0 with out_rdy=1 after one transfer -> out_vld falls to 0 next cycle, out holds the last value.
REQ-035 Reset: rst_n low mid-cycle while out_vld=1 -> out_vld, out, out_ch drop to 0 without a clock edge; after release, a scan grant starts searching at channel 0.
REQ-036 With MUX_GRANT_CNT_EN: 70000 back-to-back grants -> grant_cnt=0xFFFF and holds there.
